// File: rtl/f3_ibuff_dispatch_if.sv
// Fetch-line ingress (from f2) and instruction egress (to decode) for the f3 buffer.
// "slave" is the buffer's view; "master" drives lines and the decode ready.
interface f3_ibuff_dispatch_if #(
    parameter int XLEN    = 32,
    parameter int CL_SIZE = 128
);
    logic               line_valid;
    logic               line_ready;
    logic [CL_SIZE-1:0] line_data;
    logic [XLEN-1:0]    line_pc;
    logic               line_exc;
    logic               inst_valid;
    logic               inst_ready;
    logic [XLEN-1:0]    inst;
    logic [XLEN-1:0]    inst_pc;
    logic               inst_exc;

    modport master (
        output line_valid, line_data, line_pc, line_exc, inst_ready,
        input  line_ready, inst_valid, inst, inst_pc, inst_exc
    );

    modport slave (
        input  line_valid, line_data, line_pc, line_exc, inst_ready,
        output line_ready, inst_valid, inst, inst_pc, inst_exc
    );
endinterface

// File: rtl/f3_ibuff_dispatch.sv
// Fetch stage 3: queues fetch lines and hands one instruction per cycle to decode.
// Exception lines collapse to a single NOP packet tagged with the exception.
module f3_ibuff_dispatch #(
    parameter int XLEN    = 32,
    parameter int CL_SIZE = 128,
    parameter int DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    f3_ibuff_dispatch_if.slave       bus,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int SLOTS  = CL_SIZE / XLEN;
    localparam int SLOT_W = $clog2(SLOTS);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    localparam logic [XLEN-1:0]  NOP  = XLEN'(32'h0000_0013);

    // pc[1:0] is never stored; only the word address matters
    logic [DEPTH-1:0][SLOTS-1:0][XLEN-1:0] data_q;
    logic [DEPTH-1:0][XLEN-3:0]            pc_q;
    logic [DEPTH-1:0]                      exc_q;

    logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d, rptr_nxt;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [SLOT_W-1:0] slot_q, slot_d;

    logic push, disp, pop, head_exc;
    logic [XLEN-3:0]  head_pc;
    logic [XLEN-1:0]  head_word;
    logic [1:0]       unused_pc_lsb;

    assign unused_pc_lsb = bus.line_pc[1:0];

    assign rptr_nxt  = rptr_q + PTR_W'(1);
    assign head_pc   = pc_q[rptr_q];
    assign head_exc  = exc_q[rptr_q];
    assign head_word = data_q[rptr_q][slot_q];

    assign bus.line_ready = (count_q < FULL);
    assign bus.inst_valid = (count_q != '0);
    assign bus.inst       = head_exc ? NOP : head_word;
    assign bus.inst_exc   = head_exc;
    assign bus.inst_pc    = {head_pc[XLEN-3:SLOT_W], slot_q, 2'b00};
    assign occupancy      = count_q;

    assign push = bus.line_valid && bus.line_ready && !flush;
    assign disp = bus.inst_valid && bus.inst_ready;
    assign pop  = disp && ((slot_q == '1) || head_exc);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        slot_d  = slot_q;
        if (push) wptr_d = wptr_q + PTR_W'(1);
        if (pop)  rptr_d = rptr_nxt;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // with a single entry, the next head is the line arriving this cycle (if any)
        if (pop) begin
            if (count_q > CNT_W'(1)) slot_d = pc_q[rptr_nxt][SLOT_W-1:0];
            else if (push)           slot_d = bus.line_pc[SLOT_W+1:2];
            else                     slot_d = '0;
        end else if (disp) begin
            slot_d = slot_q + SLOT_W'(1);
        end else if (push && count_q == '0) begin
            slot_d = bus.line_pc[SLOT_W+1:2];
        end
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            slot_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            slot_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            slot_q  <= slot_d;
        end
    end

    // payload storage carries no reset; it is only observed while valid
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wptr_q] <= bus.line_data;
            pc_q[wptr_q]   <= bus.line_pc[XLEN-1:2];
            exc_q[wptr_q]  <= bus.line_exc;
        end
    end
endmodule
